// File: rtl/round_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : round_timer_ctrl
//  Purpose  : Two-digit countdown timer with prescaled tick and expiry blink.
//  Revision : 1.0
// ============================================================================
module round_timer_ctrl #(
    parameter int CLKS_PER_TICK = 50000000,
    parameter int MAX_TIME      = 99,
    parameter int BLINK_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] load_value,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] time_value,
    output logic       running,
    output logic       expired,
    output logic       blank,
    output logic       tick
);

    localparam int c_presc_w = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int c_blink_w = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLKS_PER_TICK - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_TICKS - 1);
    localparam logic [7:0]           c_max_time   = 8'(MAX_TIME);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [7:0]           r_time_q, w_time_d;
    logic [c_presc_w-1:0] r_presc_q, w_presc_d;
    logic [c_blink_w-1:0] r_blink_q, w_blink_d;
    logic                 r_blank_q, w_blank_d;
    logic                 r_tick_q, w_tick_d;
    logic                 r_running_q, r_expired_q;

    logic [7:0]           w_load_sat;
    logic                 w_presc_wrap;

    assign w_load_sat   = (load_value > c_max_time) ? c_max_time : load_value;
    assign w_presc_wrap = (r_presc_q == c_presc_last);

    // Commands that are not legal in the current state fall through to the
    // next lower-priority command, then to normal counting.
    always_comb begin
        w_state_d = r_state_q;
        w_time_d  = r_time_q;
        w_presc_d = r_presc_q;
        w_blink_d = r_blink_q;
        w_blank_d = r_blank_q;
        w_tick_d  = 1'b0;

        if (clear) begin
            w_state_d = ST_IDLE;
            w_time_d  = 8'd0;
            w_presc_d = '0;
            w_blink_d = '0;
            w_blank_d = 1'b0;
        end else if (load && (r_state_q != ST_RUN)) begin
            w_state_d = ST_IDLE;
            w_time_d  = w_load_sat;
            w_presc_d = '0;
            w_blink_d = '0;
            w_blank_d = 1'b0;
        end else if (start && (r_state_q == ST_IDLE)) begin
            w_state_d = (r_time_q != 8'd0) ? ST_RUN : ST_EXPIRED;
            w_presc_d = '0;
            w_blink_d = '0;
            w_blank_d = 1'b0;
        end else if (start && (r_state_q == ST_PAUSED)) begin
            // Prescaler is kept so the partial second survives the pause.
            w_state_d = ST_RUN;
        end else if (pause && (r_state_q == ST_RUN)) begin
            w_state_d = ST_PAUSED;
        end else if (r_state_q == ST_RUN) begin
            if (w_presc_wrap) begin
                w_presc_d = '0;
                w_tick_d  = 1'b1;
                if (r_time_q != 8'd0) begin
                    w_time_d = r_time_q - 8'd1;
                end
                if (r_time_q <= 8'd1) begin
                    w_state_d = ST_EXPIRED;
                    w_blink_d = '0;
                    w_blank_d = 1'b0;
                end
            end else begin
                w_presc_d = r_presc_q + c_presc_w'(1);
            end
        end else if (r_state_q == ST_EXPIRED) begin
            if (w_presc_wrap) begin
                w_presc_d = '0;
                w_tick_d  = 1'b1;
                if (r_blink_q == c_blink_last) begin
                    w_blink_d = '0;
                    w_blank_d = ~r_blank_q;
                end else begin
                    w_blink_d = r_blink_q + c_blink_w'(1);
                end
            end else begin
                w_presc_d = r_presc_q + c_presc_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= ST_IDLE;
            r_time_q    <= 8'd0;
            r_presc_q   <= '0;
            r_blink_q   <= '0;
            r_blank_q   <= 1'b0;
            r_tick_q    <= 1'b0;
            r_running_q <= 1'b0;
            r_expired_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_time_q    <= w_time_d;
            r_presc_q   <= w_presc_d;
            r_blink_q   <= w_blink_d;
            r_blank_q   <= w_blank_d;
            r_tick_q    <= w_tick_d;
            r_running_q <= (w_state_d == ST_RUN);
            r_expired_q <= (w_state_d == ST_EXPIRED);
        end
    end

    assign time_value = r_time_q;
    assign running    = r_running_q;
    assign expired    = r_expired_q;
    assign blank      = r_blank_q;
    assign tick       = r_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_round_timer_ctrl
//  Purpose  : Table vectors, corner sequences and random stimulus vs a model.
//  Revision : 1.0
// ============================================================================
module tb_round_timer_ctrl;

    localparam int CLKS  = 4;
    localparam int MAXT  = 99;
    localparam int BLINK = 1;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_EXP    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] time_value;
    logic       running, expired, blank, tick;

    round_timer_ctrl #(
        .CLKS_PER_TICK(CLKS),
        .MAX_TIME     (MAXT),
        .BLINK_TICKS  (BLINK)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_value(load_value),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .time_value(time_value),
        .running   (running),
        .expired   (expired),
        .blank     (blank),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: seconds left, cycles into the current second,
    // ticks seen since expiry.
    int m_st, m_t, m_sub, m_n, m_tick;

    typedef struct {
        logic [7:0] lv;
        logic       ld, st, ps, cl;
        int         t, r, e, b, k;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int et, input int er,
                              input int ee, input int eb, input int ek);
        check({tag, ".time"},    int'(time_value), et);
        check({tag, ".running"}, int'(running),    er);
        check({tag, ".expired"}, int'(expired),    ee);
        check({tag, ".blank"},   int'(blank),      eb);
        check({tag, ".tick"},    int'(tick),       ek);
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_t = 0; m_sub = 0; m_n = 0; m_tick = 0;
    endtask

    task automatic model_step(input int lv, input bit ld, input bit st,
                              input bit ps, input bit cl);
        m_tick = 0;
        if (cl) begin
            m_st = M_IDLE; m_t = 0; m_sub = 0; m_n = 0;
        end else if (ld && m_st != M_RUN) begin
            m_t = (lv > MAXT) ? MAXT : lv;
            m_st = M_IDLE; m_sub = 0; m_n = 0;
        end else if (st && m_st == M_IDLE) begin
            m_sub = 0; m_n = 0;
            m_st = (m_t > 0) ? M_RUN : M_EXP;
        end else if (st && m_st == M_PAUSED) begin
            m_st = M_RUN;
        end else if (ps && m_st == M_RUN) begin
            m_st = M_PAUSED;
        end else if (m_st == M_RUN || m_st == M_EXP) begin
            m_sub++;
            if (m_sub == CLKS) begin
                m_sub = 0;
                m_tick = 1;
                if (m_st == M_RUN) begin
                    m_t--;
                    if (m_t == 0) begin
                        m_st = M_EXP;
                        m_n = 0;
                    end
                end else begin
                    m_n++;
                end
            end
        end
    endtask

    function automatic int m_blank();
        return (m_st == M_EXP && ((m_n / BLINK) % 2) == 1) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        check_outs(tag, m_t, (m_st == M_RUN) ? 1 : 0, (m_st == M_EXP) ? 1 : 0,
                   m_blank(), m_tick);
    endtask

    task automatic cycle(input logic [7:0] lv, input logic ld, input logic st,
                         input logic ps, input logic cl);
        load_value = lv; load = ld; start = st; pause = ps; clear = cl;
        @(posedge clk);
        model_step(int'(lv), ld, st, ps, cl);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic idle_checked(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_model(tag);
        end
    endtask

    task automatic add(input logic [7:0] lv, input logic ld, input logic st,
                       input logic ps, input logic cl, input int t, input int r,
                       input int e, input int b, input int k);
        vec_t v;
        v.lv = lv; v.ld = ld; v.st = st; v.ps = ps; v.cl = cl;
        v.t = t; v.r = r; v.e = e; v.b = b; v.k = k;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int n, input int t, input int r, input int e,
                            input int b, input int k);
        for (int i = 0; i < n; i++) add(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, t, r, e, b, k);
    endtask

    initial begin
        int cnt;
        bit found;
        model_reset();

        // Reset held for three cycles, then quiet idle.
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle_checked(8, "idle");

        // Basic countdown, expiry blink, saturation, start at zero.
        add(8'd3,   1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0);
        add(8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 0, 0);
        add_idle(3, 3, 1, 0, 0, 0);
        add_idle(1, 2, 1, 0, 0, 1);
        add_idle(3, 2, 1, 0, 0, 0);
        add_idle(1, 1, 1, 0, 0, 1);
        add_idle(3, 1, 1, 0, 0, 0);
        add_idle(1, 0, 0, 1, 0, 1);
        add_idle(3, 0, 0, 1, 0, 0);
        add_idle(1, 0, 0, 1, 1, 1);
        add_idle(3, 0, 0, 1, 1, 0);
        add_idle(1, 0, 0, 1, 0, 1);
        add(8'd150, 1'b1, 1'b0, 1'b0, 1'b0, 99, 0, 0, 0, 0);
        add(8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        add(8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0);
        add_idle(3, 0, 0, 1, 0, 0);
        add_idle(1, 0, 0, 1, 1, 1);
        add(8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            cycle(tbl[i].lv, tbl[i].ld, tbl[i].st, tbl[i].ps, tbl[i].cl);
            check_outs($sformatf("vec%0d", i), tbl[i].t, tbl[i].r, tbl[i].e,
                       tbl[i].b, tbl[i].k);
        end

        // Pause two cycles after the first tick, hold, then resume.
        cycle(8'd5, 1'b1, 1'b0, 1'b0, 1'b0); check_model("pr_load");
        cycle(8'd0, 1'b0, 1'b1, 1'b0, 1'b0); check_model("pr_start");
        idle_checked(CLKS, "pr_first_tick");
        idle_checked(2, "pr_pre_pause");
        cycle(8'd0, 1'b0, 1'b0, 1'b1, 1'b0); check_model("pr_pause");
        idle_checked(20, "pr_hold");
        check("pr_hold_time", int'(time_value), 4);
        cycle(8'd0, 1'b0, 1'b1, 1'b0, 1'b0); check_model("pr_resume");
        cnt = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_model("pr_after_resume");
            cnt++;
            if (tick) found = 1;
        end
        check("pr_resume_latency", found ? cnt : -1, 2);

        // Simultaneous commands.
        cycle(8'd9, 1'b1, 1'b0, 1'b1, 1'b0); check_model("sim_ld_ps");
        check("sim_ld_ps_running", int'(running), 0);
        check("sim_ld_ps_time", int'(time_value), 3);
        cycle(8'd0, 1'b0, 1'b1, 1'b0, 1'b1); check_model("sim_cl_st");
        check("sim_cl_st_time", int'(time_value), 0);

        // Asynchronous reset mid-count at time_value 7.
        cycle(8'd9, 1'b1, 1'b0, 1'b0, 1'b0); check_model("ar_load");
        cycle(8'd0, 1'b0, 1'b1, 1'b0, 1'b0); check_model("ar_start");
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_model("ar_count");
            if (time_value == 8'd7) found = 1;
        end
        check("ar_reached_7", int'(found), 1);
        #3 rst_n = 1'b0;
        #1 check_outs("ar_async", 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_checked(12, "ar_after_release");

        // Randomized commands against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [7:0] lv;
            logic ld, st, ps, cl;
            r  = int'($urandom_range(0, 99));
            cl = (r < 2);
            ld = (r >= 2 && r < 7);
            st = (r >= 7 && r < 17);
            ps = (r >= 17 && r < 22);
            if (r >= 96) begin
                cl = 1'($urandom); ld = 1'($urandom);
                st = 1'($urandom); ps = 1'($urandom);
            end
            lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8))
                                              : 8'($urandom_range(0, 255));
            cycle(lv, ld, st, ps, cl);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
